ram_arbiter_2port: RTL and testbench



---
 rtl/ram_arbiter_2port.sv | 88 ++++++++
 tb/tb_ram_arbiter_2port.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter_2port.sv
// ram_arbiter_2port: round-robin sharing of one 128x32 sync-write/async-read RAM between two requesters.
// Define RAM_ARB_FIXED_PRIO_EN for fixed priority (port 0 always wins contention).
module ram_arbiter_2port #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  gnt0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_d,
  input  logic [DATA_WIDTH-1:0] ram_q
);
  logic                  cmd_valid_q, cmd_valid_d;
  logic                  cmd_port_q, cmd_port_d;
  logic                  ram_we_q, ram_we_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_d_q, ram_d_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rvalid0_q, rvalid0_d;
  logic                  rvalid1_q, rvalid1_d;
`ifdef RAM_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt0 = !reset && req0;
    gnt1 = !reset && req1 && !req0;
  end
`else
  logic last_q, last_d;
  // last_q = 1 means port 1 was granted last, so port 0 wins the next contention
  always_comb begin
    gnt0   = !reset && req0 && (!req1 || last_q);
    gnt1   = !reset && req1 && (!req0 || !last_q);
    last_d = gnt1 ? 1'b1 : gnt0 ? 1'b0 : last_q;
  end
  always_ff @(posedge clk) last_q <= reset ? 1'b1 : last_d;
`endif
  always_comb begin
    cmd_valid_d = gnt0 || gnt1;
    cmd_port_d  = gnt1;
    ram_we_d    = gnt1 ? we1 : (gnt0 && we0);
    ram_addr_d  = gnt1 ? addr1 : gnt0 ? addr0 : ram_addr_q;
    ram_d_d     = gnt1 ? wdata1 : gnt0 ? wdata0 : ram_d_q;
    rvalid0_d   = cmd_valid_q && !ram_we_q && !cmd_port_q;
    rvalid1_d   = cmd_valid_q && !ram_we_q && cmd_port_q;
    rdata_d     = (cmd_valid_q && !ram_we_q) ? ram_q : rdata_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_valid_q <= 1'b0;
      cmd_port_q  <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_d_q     <= '0;
      rdata_q     <= '0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
    end else begin
      cmd_valid_q <= cmd_valid_d;
      cmd_port_q  <= cmd_port_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_d_q     <= ram_d_d;
      rdata_q     <= rdata_d;
      rvalid0_q   <= rvalid0_d;
      rvalid1_q   <= rvalid1_d;
    end
  end
  // a write sitting in stage C is squashed as soon as reset rises
  assign ram_we   = ram_we_q && !reset;
  assign ram_addr = ram_addr_q;
  assign ram_d    = ram_d_q;
  assign rdata    = rdata_q;
  assign rvalid0  = rvalid0_q;
  assign rvalid1  = rvalid1_q;
endmodule

// File: tb/tb_ram_arbiter_2port.sv
// tb_ram_arbiter_2port: directed self-checking bench with a behavioural 128x32 RAM.
// Expectations follow RAM_ARB_FIXED_PRIO_EN when it is defined.
module tb_ram_arbiter_2port;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [6:0]  addr0 = '0, addr1 = '0;
  logic [31:0] wdata0 = '0, wdata1 = '0;
  logic        gnt0, gnt1, rvalid0, rvalid1, ram_we;
  logic [31:0] rdata, ram_d, ram_q;
  logic [6:0]  ram_addr;
  logic [31:0] mem [128];
  int vectors = 0;
  int errors = 0;
`ifdef RAM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif
  localparam logic [31:0] VAL_A = 32'h0000_000A;
  localparam logic [31:0] VAL_B = 32'h0000_000B;
  localparam logic [31:0] VAL_7F = 32'h0BAD_F00D;
  ram_arbiter_2port dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1),
    .rdata(rdata), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_d(ram_d), .ram_q(ram_q)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_d;
  assign ram_q = mem[ram_addr];
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic test_reset();
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      vectors++;
      if ({gnt0, gnt1, ram_we, rvalid0, rvalid1} !== 5'b0) begin
        errors++;
        $display("FAIL reset_ctl cyc%0d got gnt0=%b gnt1=%b ram_we=%b rv0=%b rv1=%b exp all 0", i, gnt0, gnt1, ram_we, rvalid0, rvalid1);
      end
      vectors++;
      if (rdata !== 32'h0 || ram_addr !== 7'h0 || ram_d !== 32'h0) begin
        errors++;
        $display("FAIL reset_data cyc%0d got rdata=%h ram_addr=%h ram_d=%h exp 0", i, rdata, ram_addr, ram_d);
      end
    end
    @(negedge clk);
    reset = 1'b0; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
  endtask
  task automatic test_write_read();
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = 7'h12; wdata0 = 32'hDEAD_BEEF;
    #1;
    vectors++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin errors++; $display("FAIL wr_gnt got gnt0=%b gnt1=%b exp 1/0", gnt0, gnt1); end
    @(negedge clk);
    we0 = 1'b0;
    #1;
    vectors++;
    if (ram_we !== 1'b1 || ram_addr !== 7'h12 || ram_d !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL wr_stage got we=%b addr=%h d=%h exp 1/12/deadbeef", ram_we, ram_addr, ram_d);
    end
    vectors++;
    if (gnt0 !== 1'b1) begin errors++; $display("FAIL rd_gnt got gnt0=%b exp 1", gnt0); end
    @(negedge clk);
    req0 = 1'b0;
    #1;
    vectors++;
    if (ram_we !== 1'b0 || ram_addr !== 7'h12 || rvalid0 !== 1'b0) begin
      errors++;
      $display("FAIL rd_stage got we=%b addr=%h rv0=%b exp 0/12/0", ram_we, ram_addr, rvalid0);
    end
    @(negedge clk);
    #1;
    vectors++;
    if (rvalid0 !== 1'b1 || rvalid1 !== 1'b0 || rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL raw_resp got rv0=%b rv1=%b rdata=%h exp 1/0/deadbeef", rvalid0, rvalid1, rdata);
    end
    @(negedge clk);
    #1;
    vectors++;
    if (rvalid0 !== 1'b0) begin errors++; $display("FAIL rv0_pulse got rv0=%b exp 0", rvalid0); end
  endtask
  task automatic test_alternate();
    bit p;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      req0 = (i < 6); req1 = (i < 6); we0 = 1'b0; we1 = 1'b0; addr0 = 7'h01; addr1 = 7'h02;
      #1;
      if (i < 6) begin
        p = FIXED ? 1'b0 : i[0];
        vectors++;
        if (gnt0 !== !p || gnt1 !== p) begin
          errors++;
          $display("FAIL alt_gnt cyc%0d got gnt0=%b gnt1=%b exp %b/%b", i, gnt0, gnt1, !p, p);
        end
      end
      if (i >= 2) begin
        p = FIXED ? 1'b0 : i[0];
        vectors++;
        if (rvalid0 !== !p || rvalid1 !== p || rdata !== (p ? VAL_B : VAL_A)) begin
          errors++;
          $display("FAIL alt_resp cyc%0d got rv0=%b rv1=%b rdata=%h exp %b/%b/%h", i, rvalid0, rvalid1, rdata, !p, p, p ? VAL_B : VAL_A);
        end
      end
    end
  endtask
  task automatic test_reset_mid_write();
    @(negedge clk);
    req1 = 1'b1; we1 = 1'b1; addr1 = 7'h7F; wdata1 = 32'h5555_AAAA;
    #1;
    vectors++;
    if (gnt1 !== 1'b1) begin errors++; $display("FAIL mid_gnt got gnt1=%b exp 1", gnt1); end
    @(negedge clk);
    req1 = 1'b0; req0 = 1'b1; reset = 1'b1;
    #1;
    vectors++;
    if (ram_we !== 1'b0 || gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
      errors++;
      $display("FAIL mid_drop got ram_we=%b gnt0=%b gnt1=%b exp 0/0/0", ram_we, gnt0, gnt1);
    end
    @(negedge clk);
    reset = 1'b0; req0 = 1'b0;
    req1 = 1'b1; we1 = 1'b0;
    #1;
    vectors++;
    if (gnt1 !== 1'b1 || rvalid1 !== 1'b0) begin errors++; $display("FAIL mid_rd got gnt1=%b rv1=%b exp 1/0", gnt1, rvalid1); end
    @(negedge clk);
    req1 = 1'b0;
    @(negedge clk);
    #1;
    vectors++;
    if (rvalid1 !== 1'b1 || rdata !== VAL_7F) begin
      errors++;
      $display("FAIL mid_old got rv1=%b rdata=%h exp 1/%h", rvalid1, rdata, VAL_7F);
    end
  endtask
  task automatic test_single_port1();
    logic [31:0] exp_d [4];
    exp_d[0] = 32'hC0DE_0000; exp_d[1] = VAL_A; exp_d[2] = VAL_B; exp_d[3] = 32'hC0DE_0003;
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b0; addr0 = 7'h00;
    @(negedge clk);
    req0 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      req1 = (i < 4); we1 = 1'b0; addr1 = 7'(i);
      #1;
      if (i < 4) begin
        vectors++;
        if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
          errors++;
          $display("FAIL p1_gnt cyc%0d got gnt0=%b gnt1=%b exp 0/1", i, gnt0, gnt1);
        end
      end
      if (i >= 2) begin
        vectors++;
        if (rvalid1 !== 1'b1 || rvalid0 !== 1'b0 || rdata !== exp_d[i-2]) begin
          errors++;
          $display("FAIL p1_resp cyc%0d got rv0=%b rv1=%b rdata=%h exp 0/1/%h", i, rvalid0, rvalid1, rdata, exp_d[i-2]);
        end
      end
    end
    @(negedge clk);
    req1 = 1'b0;
  endtask
`ifdef RAM_ARB_FIXED_PRIO_EN
  task automatic test_fixed_prio();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      req0 = (i < 5); req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
      #1;
      vectors++;
      if (gnt0 !== (i < 5) || gnt1 !== (i == 5)) begin
        errors++;
        $display("FAIL fixed_gnt cyc%0d got gnt0=%b gnt1=%b exp %b/%b", i, gnt0, gnt1, i < 5, i == 5);
      end
    end
    @(negedge clk);
    req1 = 1'b0;
  endtask
`endif
  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
    mem[1] = VAL_A;
    mem[2] = VAL_B;
    mem[127] = VAL_7F;
    test_reset();
    test_write_read();
    test_alternate();
    test_reset_mid_write();
    test_single_port1();
`ifdef RAM_ARB_FIXED_PRIO_EN
    test_fixed_prio();
`endif
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
